// File: rtl/mmul_loader.sv
// Streams matrix A then matrix B element by element into registered row-major buffers,
// then holds them stable with enable asserted until the multiplier reports completion.
module mmul_loader #(
  parameter int unsigned RA = 0,
  parameter int unsigned CA = 0,
  parameter int unsigned RB = 0,
  parameter int unsigned CB = 0,
  parameter int unsigned W  = 32,
  localparam int unsigned A_W = ((RA * CA) == 0 ? 1 : RA * CA) * W,
  localparam int unsigned B_W = ((RB * CB) == 0 ? 1 : RB * CB) * W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic [A_W-1:0] A,
  output logic [B_W-1:0] B,
  output logic           enable,
  input  logic           completed,
  output logic           batch_done,
  output logic           dim_error
);

  localparam int unsigned N_A   = RA * CA;
  localparam int unsigned N_B   = RB * CB;
  localparam int unsigned N_MAX = (N_A > N_B) ? N_A : N_B;
  localparam int unsigned IDX_W = (N_MAX < 2) ? 1 : $clog2(N_MAX);
  localparam bit DIM_ERR = (CA != RB) || (RA == 0) || (CA == 0) || (RB == 0) || (CB == 0);
  localparam logic [IDX_W-1:0] A_LAST = IDX_W'(N_A - 1);
  localparam logic [IDX_W-1:0] B_LAST = IDX_W'(N_B - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic             enable_q, enable_d;
  logic             batch_done_q, batch_done_d;
  logic             xfer_c;
  int unsigned      off_c;

  // A dimension mismatch parks the loader in LOAD_A with no handshake ever offered.
  assign in_ready   = (state_q != RUN) && !DIM_ERR;
  assign dim_error  = DIM_ERR;
  assign A          = a_q;
  assign B          = b_q;
  assign enable     = enable_q;
  assign batch_done = batch_done_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    batch_done_d = 1'b0;
    xfer_c       = in_valid && in_ready;
    off_c        = W * 32'(idx_q);
    case (state_q)
      LOAD_A: begin
        if (xfer_c) begin
          a_d[off_c +: W] = in_data;
          if (idx_q == A_LAST) begin
            state_d = LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (xfer_c) begin
          b_d[off_c +: W] = in_data;
          if (idx_q == B_LAST) begin
            state_d = RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      RUN: begin
        if (completed) begin
          state_d      = LOAD_A;
          idx_d        = '0;
          batch_done_d = 1'b1;
        end
      end
      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase
    // enable tracks the registered state exactly.
    enable_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD_A;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      enable_q     <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      enable_q     <= enable_d;
      batch_done_q <= batch_done_d;
    end
  end

endmodule

// File: tb/tb_mmul_loader.sv
// Directed bench for mmul_loader: a valid 2x2 configuration and a mismatched 2x3/2x2 one.
module tb_mmul_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        completed;
  logic [7:0]  in_data;
  logic        in_ready, enable, batch_done, dim_error;
  logic [31:0] a, b;

  logic        v1, c1;
  logic [7:0]  d1;
  logic        rdy1, en1, bd1, de1;
  logic [47:0] a1;
  logic [31:0] b1;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmul_loader #(.RA(2), .CA(2), .RB(2), .CB(2), .W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .A(a), .B(b), .enable(enable), .completed(completed), .batch_done(batch_done),
    .dim_error(dim_error)
  );

  mmul_loader #(.RA(2), .CA(3), .RB(2), .CB(2), .W(8)) u_bad (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .A(a1), .B(b1), .enable(en1), .completed(c1), .batch_done(bd1),
    .dim_error(de1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; completed = 1'b0; in_data = 8'h00;
    v1 = 1'b0; c1 = 1'b0; d1 = 8'h00;
    step;
    rst = 1'b0;
    check("rst_a", 64'(a), 64'h0);
    check("rst_b", 64'(b), 64'h0);
    check("rst_en_bd_rdy", 64'({enable, batch_done, in_ready}), 64'b001);
    check("rst_dim", 64'(dim_error), 64'h0);

    // completed during LOAD_A is ignored
    completed = 1'b1;
    step;
    completed = 1'b0;
    check("cmp_in_load", 64'({enable, batch_done, in_ready}), 64'b001);

    // back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step;
      if (i == 7) check("pre_run", 64'({enable, in_ready}), 64'b01);
    end
    in_valid = 1'b0;
    check("stream_a", 64'(a), 64'h04030201);
    check("stream_b", 64'(b), 64'h08070605);
    check("run_en_rdy", 64'({enable, in_ready}), 64'b10);

    // RUN holds for 10 cycles; offered data must be ignored
    in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step;
      check($sformatf("run_hold%0d", i), 64'({enable, in_ready, batch_done}), 64'b100);
    end
    check("run_a_hold", 64'(a), 64'h04030201);
    check("run_b_hold", 64'(b), 64'h08070605);
    in_valid = 1'b0;
    completed = 1'b1;
    step;
    completed = 1'b0;
    check("done_edge", 64'({enable, in_ready, batch_done}), 64'b011);
    step;
    check("done_pulse_end", 64'({enable, in_ready, batch_done}), 64'b010);

    // gapped stream 0x11..0x18 with valid pattern 1,0,0,...
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 100) begin
      in_valid = (cyc % 3 == 0);
      in_data  = in_valid ? 8'(8'h11 + n) : 8'hEE;
      step;
      if (in_valid) n++;
      if (cyc == 0) check("retain_prev", 64'(a), 64'h04030211);
      if (cyc == 2) check("gap_hold", 64'(a), 64'h04030211);
      if (cyc == 3) check("after_gap", 64'(a), 64'h04031211);
      cyc++;
    end
    in_valid = 1'b0;
    check("gap_count", 64'(n), 64'd8);
    check("gap_a", 64'(a), 64'h14131211);
    check("gap_b", 64'(b), 64'h18171615);
    check("gap_run", 64'({enable, in_ready}), 64'b10);
    completed = 1'b1;
    step;
    completed = 1'b0;
    check("gap_done", 64'({enable, batch_done}), 64'b01);

    // reset after the 6th transfer, with a transfer offered on the reset edge
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h21 + i);
      step;
    end
    check("mid_b_a", 64'(a), 64'h24232221);
    check("mid_b_b", 64'(b), 64'h18172625);
    rst = 1'b1; in_data = 8'h77;
    step;
    rst = 1'b0;
    check("mid_rst_a", 64'(a), 64'h0);
    check("mid_rst_b", 64'(b), 64'h0);
    check("mid_rst_ctl", 64'({enable, batch_done, in_ready}), 64'b001);
    in_data = 8'h09;
    step;
    in_valid = 1'b0;
    check("post_rst_a0", 64'(a), 64'h00000009);
    check("post_rst_b", 64'(b), 64'h0);

    // mismatched dimensions never handshake or run
    check("bad_dim", 64'(de1), 64'h1);
    for (int i = 0; i < 20; i++) begin
      v1 = ~v1;
      d1 = 8'(i + 1);
      c1 = (i % 4 == 1);
      step;
      check($sformatf("bad_ctl%0d", i), 64'({rdy1, en1, bd1}), 64'b000);
    end
    check("bad_a", 64'(a1), 64'h0);
    check("bad_b", 64'(b1), 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
